// File: rtl/dpc_io_pkg.sv
// Shared definitions for the external I/O register bus scheduler.
// Contents: scheduler state enum, bus field widths, enable-strobe bit indices.
// No logic; imported by io_bus_scheduler.
package dpc_io_pkg;

  localparam int IO_BOARD_WIDTH = 8;
  localparam int IO_ADDR_WIDTH  = 4;

  // Bit positions inside the active-low io_enable_n strobe pair.
  localparam int IO_EN_READ  = 0;
  localparam int IO_EN_WRITE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_READ,
    ST_WRITE,
    ST_HOLD
  } io_sched_state_t;

endpackage

// File: rtl/io_bus_scheduler.sv
// Scans installed I/O boards (read input byte, write output byte) and interleaves priority writes.
// Latency: scan slot 3+2*STROBE_CYCLES cycles, request slot 3+STROBE_CYCLES; all outputs registered.
// Backpressure: req_valid holds until the one-cycle req_ready; a request never follows a request slot.
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   outputs / inputs    CPU-side output bytes in, registered input mirror out (board b at [b*8+:8])
//   req_valid/board/data, req_ready   priority write request and its acceptance pulse
//   io_address, io_enable_n, io_data_out, io_data_oe, io_data_in   external register bus
//   scan_done           one-cycle pulse after the last installed board of each scan
module io_bus_scheduler
  import dpc_io_pkg::*;
#(
  parameter int BOARDS           = 16,
  parameter int INSTALLED_BOARDS = 2,
  parameter int STROBE_CYCLES    = 4
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic [BOARDS*IO_BOARD_WIDTH-1:0]   outputs,
  output logic [BOARDS*IO_BOARD_WIDTH-1:0]   inputs,
  input  logic                               req_valid,
  input  logic [IO_ADDR_WIDTH-1:0]           req_board,
  input  logic [IO_BOARD_WIDTH-1:0]          req_data,
  output logic                               req_ready,
  output logic [IO_ADDR_WIDTH-1:0]           io_address,
  output logic [1:0]                         io_enable_n,
  output logic [IO_BOARD_WIDTH-1:0]          io_data_out,
  output logic                               io_data_oe,
  input  logic [IO_BOARD_WIDTH-1:0]          io_data_in,
  output logic                               scan_done
);

  localparam int PH_W      = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int PH_LAST_I = STROBE_CYCLES - 1;
  localparam int IDX_LAST_I = INSTALLED_BOARDS - 1;
  localparam logic [PH_W-1:0]          PH_LAST   = PH_LAST_I[PH_W-1:0];
  localparam logic [IO_ADDR_WIDTH-1:0] IDX_LAST  = IDX_LAST_I[IO_ADDR_WIDTH-1:0];
  localparam logic [IO_ADDR_WIDTH:0]   INSTALLED = INSTALLED_BOARDS[IO_ADDR_WIDTH:0];

  io_sched_state_t              state, state_d;
  logic [PH_W-1:0]              phase, phase_d;
  logic [IO_ADDR_WIDTH-1:0]     scan_idx;
  logic                         req_slot;      // current slot is a priority write
  logic [IO_ADDR_WIDTH-1:0]     req_board_q;
  logic [IO_BOARD_WIDTH-1:0]    data_reg;
  logic [IO_BOARD_WIDTH-1:0]    out_sel;
  logic [1:0]                   en_n_d;
  logic                         oe_d;
  logic                         grant;
  logic                         scan_wrap;
  logic                         read_last;
  logic                         req_uninstalled;

  // Arbitration is resolved on the edge that enters IDLE, so req_ready can be a
  // registered pulse that is visible during the IDLE cycle itself. A request is
  // only granted when the slot that is ending was a scan slot (no starvation).
  assign grant           = (state == ST_HOLD) && !req_slot && req_valid;
  assign scan_wrap       = (state == ST_HOLD) && !req_slot && (scan_idx == IDX_LAST);
  assign read_last       = (state == ST_READ) && (phase == PH_LAST);
  assign req_uninstalled = ({1'b0, req_board_q} >= INSTALLED);

  // Output byte of the board being scanned.
  always_comb begin
    out_sel = '0;
    for (int b = 0; b < BOARDS; b++) begin
      if (scan_idx == b[IO_ADDR_WIDTH-1:0]) begin
        out_sel = outputs[b*IO_BOARD_WIDTH +: IO_BOARD_WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      phase <= '0;
    end else begin
      state <= state_d;
      phase <= phase_d;
    end
  end

  // Next-state logic; phase counts only inside READ and WRITE.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  state_d = (req_slot && req_uninstalled) ? ST_IDLE : ST_SETUP;
      ST_SETUP: state_d = req_slot ? ST_WRITE : ST_READ;
      ST_READ:  if (phase == PH_LAST) state_d = ST_WRITE;
      ST_WRITE: if (phase == PH_LAST) state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    phase_d = ((state_d == state) && ((state == ST_READ) || (state == ST_WRITE)))
              ? phase + 1'b1 : '0;
  end

  // Bus strobe values for the coming cycle, derived from the next state so the
  // registered outputs line up with the state they belong to. The first WRITE
  // cycle keeps the write strobe high as a bus turnaround.
  always_comb begin
    en_n_d              = 2'b11;
    en_n_d[IO_EN_READ]  = (state_d != ST_READ);
    en_n_d[IO_EN_WRITE] = !((state_d == ST_WRITE) && (phase_d != '0));
    oe_d                = (state_d == ST_WRITE);
  end

  // Output and datapath registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      io_address  <= '0;
      io_enable_n <= 2'b11;
      io_data_oe  <= 1'b0;
      io_data_out <= '0;
      inputs      <= '0;
      req_ready   <= 1'b0;
      scan_done   <= 1'b0;
      scan_idx    <= '0;
      req_slot    <= 1'b0;
      req_board_q <= '0;
      data_reg    <= '0;
    end else begin
      io_enable_n <= en_n_d;
      io_data_oe  <= oe_d;
      req_ready   <= grant;
      scan_done   <= scan_wrap;

      if (grant) begin
        req_board_q <= req_board;
        data_reg    <= req_data;
      end

      // An uninstalled request target collapses the slot to IDLE -> IDLE.
      if (state == ST_HOLD) begin
        req_slot <= grant;
      end else if ((state == ST_IDLE) && (state_d == ST_IDLE)) begin
        req_slot <= 1'b0;
      end

      if ((state == ST_HOLD) && !req_slot) begin
        scan_idx <= scan_wrap ? '0 : scan_idx + 1'b1;
      end

      // Entering SETUP: select the board; a scan slot snapshots its output byte here.
      if ((state == ST_IDLE) && (state_d == ST_SETUP)) begin
        io_address <= req_slot ? req_board_q : scan_idx;
        if (!req_slot) begin
          data_reg <= out_sel;
        end
      end

      if ((state_d == ST_WRITE) && (state != ST_WRITE)) begin
        io_data_out <= data_reg;
      end

      // Only installed slices are ever written; the rest stay at reset value.
      if (read_last) begin
        for (int b = 0; b < INSTALLED_BOARDS; b++) begin
          if (scan_idx == b[IO_ADDR_WIDTH-1:0]) begin
            inputs[b*IO_BOARD_WIDTH +: IO_BOARD_WIDTH] <= io_data_in;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_io_bus_scheduler.sv
// Bench for io_bus_scheduler: expected bus accesses/pulses are queued by the stimulus,
// a forked monitor reconstructs accesses from the bus and compares them in order.
module tb_io_bus_scheduler;

  localparam int EV_READ  = 0;
  localparam int EV_WRITE = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_RDY   = 3;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
    int l1;
    int l2;
  } ev_t;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [127:0] outputs;
  logic [127:0] inputs;
  logic         req_valid;
  logic [3:0]   req_board;
  logic [7:0]   req_data;
  logic         req_ready;
  logic [3:0]   io_address;
  logic [1:0]   io_enable_n;
  logic [7:0]   io_data_out;
  logic         io_data_oe;
  logic [7:0]   io_data_in;
  logic         scan_done;
  logic [7:0]   pad_val [16];

  int  tests = 0;
  int  fails = 0;
  int  edge_cnt = 0;
  ev_t exp_q[$];

  io_bus_scheduler dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .outputs     (outputs),
    .inputs      (inputs),
    .req_valid   (req_valid),
    .req_board   (req_board),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .io_address  (io_address),
    .io_enable_n (io_enable_n),
    .io_data_out (io_data_out),
    .io_data_oe  (io_data_oe),
    .io_data_in  (io_data_in),
    .scan_done   (scan_done)
  );

  always #5 Clk = ~Clk;

  // Pad model: each board answers with its own byte.
  assign io_data_in = pad_val[io_address];

  // Edges since reset release; at a negedge the current cycle number is edge_cnt+1.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [7:0] in_byte(input int b);
    logic [127:0] sh;
    sh = inputs >> (8 * b);
    return sh[7:0];
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic exp_ev(input int kind, input int addr, input int data, input int cyc);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = cyc;
    e.l1   = (kind == EV_READ || kind == EV_WRITE) ? 4 : 0;
    e.l2   = (kind == EV_WRITE) ? 3 : 0;
    exp_q.push_back(e);
  endtask

  // Scan slot whose IDLE is cycle c: READ starts c+2, WRITE (oe) starts c+6.
  task automatic exp_scan(input int board, input int rd, input int wr, input int c);
    exp_ev(EV_READ, board, rd, c + 2);
    exp_ev(EV_WRITE, board, wr, c + 6);
  endtask

  // Request slot whose IDLE is cycle c: req_ready in c, WRITE starts c+2.
  task automatic exp_req(input int board, input int data, input int c);
    exp_ev(EV_RDY, 0, 0, c);
    exp_ev(EV_WRITE, board, data, c + 2);
  endtask

  task automatic observe(input int kind, input int addr, input int data,
                         input int cyc, input int l1, input int l2);
    ev_t ex;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: kind %0d addr %0d data %0h cycle %0d len %0d/%0d, required none",
               kind, addr, data, cyc, l1, l2);
    end else begin
      ex = exp_q.pop_front();
      if (ex.kind != kind || ex.addr != addr || ex.data != data ||
          ex.cyc != cyc || ex.l1 != l1 || ex.l2 != l2) begin
        fails++;
        $display("FAIL event: got kind %0d addr %0d data %0h cycle %0d len %0d/%0d, required kind %0d addr %0d data %0h cycle %0d len %0d/%0d",
                 kind, addr, data, cyc, l1, l2, ex.kind, ex.addr, ex.data, ex.cyc, ex.l1, ex.l2);
      end
    end
  endtask

  task automatic monitor();
    int rd_len = 0;
    int rd_start = 0;
    int rd_addr = 0;
    int oe_len = 0;
    int wr_len = 0;
    int wr_start = 0;
    int wr_addr = 0;
    int wr_data = 0;
    bit wr_stable = 1'b1;
    int cyc;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        rd_len = 0;
        oe_len = 0;
        wr_len = 0;
      end else begin
        cyc = edge_cnt + 1;
        tests++;
        if (io_enable_n == 2'b00 || (io_data_oe && !io_enable_n[0]) ||
            (!io_enable_n[1] && !io_data_oe)) begin
          fails++;
          $display("FAIL strobe_rules: cycle %0d enable_n %b oe %b, required no overlap", cyc, io_enable_n, io_data_oe);
        end
        if (!io_enable_n[0]) begin
          if (rd_len == 0) begin
            rd_start = cyc;
            rd_addr  = int'(io_address);
          end
          rd_len++;
        end else if (rd_len != 0) begin
          observe(EV_READ, rd_addr, int'(in_byte(rd_addr)), rd_start, rd_len, 0);
          rd_len = 0;
        end
        if (io_data_oe) begin
          if (oe_len == 0) begin
            wr_start  = cyc;
            wr_addr   = int'(io_address);
            wr_data   = int'(io_data_out);
            wr_stable = 1'b1;
          end else if (int'(io_data_out) != wr_data) begin
            wr_stable = 1'b0;
          end
          oe_len++;
          if (!io_enable_n[1]) wr_len++;
        end else if (oe_len != 0) begin
          observe(EV_WRITE, wr_addr, wr_stable ? wr_data : -1, wr_start, oe_len, wr_len);
          oe_len = 0;
          wr_len = 0;
        end
        if (scan_done) begin
          observe(EV_DONE, 0, 0, cyc, 0, 0);
          check("inputs_uninstalled_zero", inputs >> 16, '0);
        end
        if (req_ready) observe(EV_RDY, 0, 0, cyc, 0, 0);
      end
    end
  endtask

  task automatic wait_cycle(input int n);
    while (edge_cnt + 1 < n) @(negedge Clk);
  endtask

  task automatic wait_rdy(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      got = req_ready;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s: req_ready 0 after 40 cycles, required 1", name);
    end
  endtask

  logic [3:0] rq_board [4];
  logic [7:0] rq_data  [4];

  initial begin
    Rst       = 1'b1;
    req_valid = 1'b0;
    req_board = '0;
    req_data  = '0;
    outputs   = '0;
    outputs[7:0]  = 8'hA5;
    outputs[15:8] = 8'h3C;
    for (int i = 0; i < 16; i++) pad_val[i] = 8'hEE;
    pad_val[0] = 8'h11;
    pad_val[1] = 8'h22;
    rq_board[0] = 4'd1; rq_data[0] = 8'h5A;
    rq_board[1] = 4'd0; rq_data[1] = 8'hC3;
    rq_board[2] = 4'd1; rq_data[2] = 8'h99;
    rq_board[3] = 4'd0; rq_data[3] = 8'h0F;

    fork
      monitor();
    join_none

    repeat (3) @(negedge Clk);
    check("reset_outputs", {io_address, io_enable_n, io_data_oe, io_data_out, req_ready, scan_done},
          {4'h0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0});
    check("reset_inputs", inputs, '0);

    // Full scan, then a priority write raised mid-slot of board 0.
    exp_scan(0, 'h11, 'hA5, 1);
    exp_scan(1, 'h22, 'h3C, 12);
    exp_ev(EV_DONE, 0, 0, 23);
    exp_scan(0, 'h11, 'hA5, 23);
    exp_req(1, 'h7E, 34);
    exp_scan(1, 'h22, 'h3C, 41);
    exp_ev(EV_DONE, 0, 0, 52);
    Rst = 1'b0;
    wait_cycle(23);
    check("scan_inputs", inputs[15:0], 16'h2211);
    wait_cycle(28);
    req_valid = 1'b1;
    req_board = 4'd1;
    req_data  = 8'h7E;
    wait_rdy("prio_rdy");
    req_valid = 1'b0;

    // Back-to-back requests: request and scan slots alternate.
    exp_scan(0, 'h11, 'hA5, 52);
    exp_req(1, 'h5A, 63);
    exp_scan(1, 'h22, 'h3C, 70);
    exp_ev(EV_DONE, 0, 0, 81);
    exp_req(0, 'hC3, 81);
    exp_scan(0, 'h11, 'hA5, 88);
    exp_req(1, 'h99, 99);
    exp_scan(1, 'h22, 'h3C, 106);
    exp_ev(EV_DONE, 0, 0, 117);
    exp_req(0, 'h0F, 117);
    wait_cycle(53);
    req_valid = 1'b1;
    req_board = rq_board[0];
    req_data  = rq_data[0];
    for (int k = 0; k < 4; k++) begin
      wait_rdy("starve_rdy");
      if (k < 3) begin
        req_board = rq_board[k+1];
        req_data  = rq_data[k+1];
      end else begin
        req_valid = 1'b0;
      end
    end

    // Uninstalled target: acknowledged, no bus access.
    exp_scan(0, 'h11, 'hA5, 124);
    exp_ev(EV_RDY, 0, 0, 135);
    exp_scan(1, 'h22, 'h3C, 136);
    exp_ev(EV_DONE, 0, 0, 147);
    exp_ev(EV_READ, 0, 'h11, 149);
    wait_cycle(127);
    req_valid = 1'b1;
    req_board = 4'd9;
    req_data  = 8'h55;
    wait_rdy("uninst_rdy");
    req_valid = 1'b0;
    wait_cycle(148);
    check("uninst_inputs", inputs[79:72], 8'h00);

    // Reset in the middle of board 0's WRITE phase (cycles 153..156).
    wait_cycle(154);
    #1 Rst = 1'b1;
    #1;
    check("midwrite_reset_outputs", {io_address, io_enable_n, io_data_oe, io_data_out, req_ready, scan_done},
          {4'h0, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0});
    check("midwrite_reset_inputs", inputs, '0);
    check("events_before_reset", exp_q.size(), 0);
    pad_val[0] = 8'h44;
    exp_scan(0, 'h44, 'hA5, 1);
    exp_scan(1, 'h22, 'h3C, 12);
    exp_ev(EV_DONE, 0, 0, 23);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    wait_cycle(5);
    check("inputs_before_first_sample", inputs, '0);
    wait_cycle(25);
    check("all_events_seen", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
